// File: rtl/seg7_pkg.sv
// Shared constants and state types for the multiplexed 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} patterns; entry n is the glyph for hex digit n
  localparam logic [15:0][SEG_W-1:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_st_e;
  typedef enum logic {IDLE  = 1'b0, PEND  = 1'b1} commit_st_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write / commit port between the nibble producers and the scan controller.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3:0]       wr_data;
  logic             wr_ready;
  logic             commit;
  logic             commit_pend;

  modport master (output wr_en, wr_addr, wr_data, commit, input wr_ready, commit_pend);
  modport slave  (input wr_en, wr_addr, wr_data, commit, output wr_ready, commit_pend);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low cathode decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = ~SEG_PAT[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a multiplexed 7-segment display with shadow/active digit buffers.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned BLANK_CYC  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_ctrl_if.slave       wr_bus,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_tick
);

  localparam int unsigned     PSC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam scan_st_e        SCAN_RST = (BLANK_CYC > 0) ? BLANK : DRIVE;

  logic [PSC_W-1:0]           r_psc;
  logic [IDX_W-1:0]           r_idx;
  logic [NUM_DIGITS-1:0][3:0] r_shadow;
  logic [NUM_DIGITS-1:0][3:0] r_active;
  scan_st_e                   r_scan_st;
  commit_st_e                 r_cm_st;
  logic [NUM_DIGITS-1:0]      r_an;
  logic [SEG_W-1:0]           r_seg;
  logic                       r_wrap_d;
  logic                       r_frame_tick;
  logic                       r_wr_ready;
  logic                       r_commit_pend;

  logic [PSC_W-1:0]           w_psc_nxt;
  logic                       w_slot_end;
  logic                       w_wrap;
  scan_st_e                   w_scan_nxt;
  commit_st_e                 w_cm_nxt;
  logic                       w_wr_acc;
  logic                       w_copy;
  logic [NUM_DIGITS-1:0]      w_lzb;
  logic [NUM_DIGITS-1:0]      w_an_nxt;
  logic [SEG_W-1:0]           w_seg_nxt;
  logic [SEG_W-1:0]           w_dec_seg;

  assign w_slot_end = (r_psc == PSC_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_psc_nxt  = w_slot_end ? '0 : r_psc + PSC_W'(1);

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc <= '0;
      r_idx <= '0;
    end else begin
      r_psc <= w_psc_nxt;
      if (w_slot_end) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_scan_st <= SCAN_RST;
    else      r_scan_st <= w_scan_nxt;
  end

  // Scan FSM: next state
  always_comb begin
    w_scan_nxt = r_scan_st;
    case (r_scan_st)
      BLANK:   if (32'(w_psc_nxt) >= BLANK_CYC) w_scan_nxt = DRIVE;
      DRIVE:   if (w_slot_end && (BLANK_CYC != 0)) w_scan_nxt = BLANK;
      default: w_scan_nxt = SCAN_RST;
    endcase
  end

  seg7_hex_decode u_dec (
    .i_nibble (r_active[r_idx]),
    .o_seg_c  (w_dec_seg)
  );

`ifdef SEG7_LZB_EN
  // Zero digits above the most significant nonzero one are suppressed; digit 0 always shows
  always_comb begin : lzb
    logic w_run;
    w_run = 1'b1;
    w_lzb = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      w_run    = w_run & (r_active[i] == 4'h0);
      w_lzb[i] = w_run;
    end
  end
`else
  assign w_lzb = '0;
`endif

  // Scan FSM: outputs
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_OFF;
    if (r_scan_st == DRIVE) begin
      w_seg_nxt       = w_dec_seg;
      w_an_nxt[r_idx] = ~(digit_en[r_idx] & ~w_lzb[r_idx]);
    end
  end

  // Commit FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cm_st <= IDLE;
    else      r_cm_st <= w_cm_nxt;
  end

  // Commit FSM: next state
  always_comb begin
    w_cm_nxt = r_cm_st;
    case (r_cm_st)
      IDLE:    if (wr_bus.commit) w_cm_nxt = PEND;
      PEND:    if (w_wrap) w_cm_nxt = IDLE;
      default: w_cm_nxt = IDLE;
    endcase
  end

  // Commit FSM: outputs; out-of-range addresses are acknowledged but dropped
  always_comb begin
    w_wr_acc = 1'b0;
    w_copy   = 1'b0;
    case (r_cm_st)
      IDLE:    w_wr_acc = wr_bus.wr_en && (32'(wr_bus.wr_addr) < NUM_DIGITS);
      PEND:    w_copy   = w_wrap;
      default: ;
    endcase
  end

  // Shadow and active digit buffers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_wr_acc) r_shadow[wr_bus.wr_addr] <= wr_bus.wr_data;
      if (w_copy)   r_active <= r_shadow;
    end
  end

  // Registered outputs; frame_tick is delayed twice to line up with an/seg of digit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an          <= '1;
      r_seg         <= SEG_OFF;
      r_wrap_d      <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_wr_ready    <= 1'b1;
      r_commit_pend <= 1'b0;
    end else begin
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_nxt;
      r_wrap_d      <= w_wrap;
      r_frame_tick  <= r_wrap_d;
      r_wr_ready    <= (w_cm_nxt == IDLE);
      r_commit_pend <= (w_cm_nxt == PEND);
    end
  end

  assign an                 = r_an;
  assign seg                = r_seg;
  assign frame_tick         = r_frame_tick;
  assign wr_bus.wr_ready    = r_wr_ready;
  assign wr_bus.commit_pend = r_commit_pend;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed steps plus random traffic against a frame-level model.
// Define SEG7_LZB_EN for both RTL and bench to cover leading-zero blanking.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND    = 8;
  localparam int unsigned CD    = 4;
  localparam int unsigned BC    = 1;
  localparam int unsigned FRAME = ND * CD;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] digit_en;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          frame_tick;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_bus     (bus),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned k;
  logic [3:0]  m_shadow [ND];
  logic [3:0]  m_active [ND];
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit lzb_blank(input int d);
`ifdef SEG7_LZB_EN
    int top = 0;
    for (int i = 0; i < int'(ND); i++) if (m_active[i] != 4'h0) top = i;
    return d > top;
`else
    return (d < 0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ND); i++) begin
      m_shadow[i] = 4'h0;
      m_active[i] = 4'h0;
    end
    m_pend = 1'b0;
    k      = 0;
  endtask

  // One clock: predict outputs of the pre-edge scan position, advance the model, compare
  task automatic tick();
    int unsigned pos, dig, slot;
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic          e_ft;
    pos   = k % FRAME;
    dig   = pos / CD;
    slot  = pos % CD;
    e_an  = '1;
    e_seg = 7'h7F;
    if (slot >= BC) begin
      e_seg = ~PAT[m_active[dig]];
      if (digit_en[dig] && !lzb_blank(int'(dig))) e_an[dig] = 1'b0;
    end
    e_ft = (k != 0) && (pos == 0);
    if (bus.wr_en && !m_pend) m_shadow[bus.wr_addr] = bus.wr_data;
    if (m_pend && pos == FRAME - 1) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end else if (!m_pend && bus.commit) begin
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    k++;
    chk("an",          32'(an),              32'(e_an));
    chk("seg",         32'(seg),             32'(e_seg));
    chk("frame_tick",  32'(frame_tick),      32'(e_ft));
    chk("wr_ready",    32'(bus.wr_ready),    32'(!m_pend));
    chk("commit_pend", 32'(bus.commit_pend), 32'(m_pend));
  endtask

  task automatic goto_pos(input int unsigned p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((k - 1) % FRAME) != p && n < int'(2 * FRAME));
    chk("goto_pos", (k - 1) % FRAME, 32'(p));
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    int n = 0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    while (bus.wr_ready !== 1'b1 && n < int'(2 * FRAME)) begin
      tick();
      n++;
    end
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.commit_pend !== 1'b0 && n < int'(2 * FRAME)) begin
      tick();
      n++;
    end
    chk("pend_clear", 32'(bus.commit_pend), 32'h0);
  endtask

  task automatic reset_checks();
    chk("rst_an",          32'(an),              32'hFF);
    chk("rst_seg",         32'(seg),             32'h7F);
    chk("rst_wr_ready",    32'(bus.wr_ready),    32'h1);
    chk("rst_commit_pend", 32'(bus.commit_pend), 32'h0);
    chk("rst_frame_tick",  32'(frame_tick),      32'h0);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    digit_en    = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b1;

    // First DRIVE after release shows digit 0 = 0, then two full scan frames
    goto_pos(1);
    chk("first_drive_seg", 32'(seg), 32'h40);
    chk("first_drive_an",  32'(an),  32'hFE);
    repeat (2 * FRAME) tick();

    // Atomic commit of 1..8, with a write held off while pending
    for (int d = 0; d < int'(ND); d++) wr(3'(d), 4'(d + 1));
    do_commit();
    chk("pend_after_commit",  32'(bus.commit_pend), 32'h1);
    chk("ready_after_commit", 32'(bus.wr_ready),    32'h0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 4'hF;
    n = 0;
    while (bus.wr_ready !== 1'b1 && n < int'(2 * FRAME)) begin
      tick();
      n++;
    end
    chk("ready_after_wrap", 32'(bus.wr_ready), 32'h1);
    tick();
    bus.wr_en = 1'b0;
    goto_pos(1);
    chk("digit0_is_1", 32'(seg), 32'h79);
    goto_pos(9);
    chk("digit2_old",  32'(seg), 32'h30);
    goto_pos(29);
    chk("digit7_is_8", 32'(seg), 32'h00);
    do_commit();
    wait_idle();
    goto_pos(9);
    chk("digit2_is_F", 32'(seg), 32'h0E);

    // Enable mask keeps upper anodes dark
    digit_en = 8'h0F;
    repeat (2 * FRAME) begin
      tick();
      chk("masked_an_hi", 32'(an[7:4]), 32'hF);
    end
    digit_en = 8'hFF;

    // Commit on the wrap cycle lands one frame later
    wr(3'd5, 4'hC);
    goto_pos(FRAME - 2);
    do_commit();
    chk("wrap_commit_pend", 32'(bus.commit_pend), 32'h1);
    goto_pos(21);
    chk("digit5_still_6", 32'(seg), 32'h02);
    wait_idle();
    goto_pos(21);
    chk("digit5_is_C", 32'(seg), 32'h46);

    // Write and commit in the same cycle
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd3;
    bus.wr_data = 4'hA;
    bus.commit  = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    wait_idle();
    goto_pos(13);
    chk("digit3_is_A", 32'(seg), 32'h08);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 3'($urandom_range(0, 7));
      bus.wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.commit  = ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 40) == 0) digit_en = 8'($urandom);
      tick();
    end
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    digit_en   = 8'hFF;
    wait_idle();

`ifdef SEG7_LZB_EN
    // Digits 7..3 are leading zeros
    for (int d = 0; d < int'(ND); d++) wr(3'(d), (d < 3) ? 4'(3 - d) : 4'h0);
    do_commit();
    wait_idle();
    goto_pos(0);
    repeat (FRAME) begin
      tick();
      chk("lzb_an_hi", 32'(an[7:3]), 32'h1F);
    end
    // All zero: only digit 0 drives
    for (int d = 0; d < 3; d++) wr(3'(d), 4'h0);
    do_commit();
    wait_idle();
    goto_pos(1);
    chk("lzb_zero_seg", 32'(seg), 32'h40);
    chk("lzb_zero_an",  32'(an),  32'hFE);
    repeat (FRAME) begin
      tick();
      chk("lzb_zero_an_hi", 32'(an[7:1]), 32'h7F);
    end
`endif

    // Asynchronous reset mid-frame drops a pending commit and clears the buffers
    wr(3'd0, 4'h9);
    do_commit();
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    goto_pos(1);
    chk("post_rst_seg", 32'(seg), 32'h40);
    do_commit();
    wait_idle();
    goto_pos(1);
    chk("post_rst_shadow_clear", 32'(seg), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
